// File: rtl/uart_top.sv
`default_nettype none
// ============================================================================
// uart_top : full-duplex 8N1 UART, runtime prescale (clock cycles per bit).
// Optional macro UART_FRAME_ERR_EN adds the rx_frame_err pulse output.
// Revision 1.0
// ============================================================================
module uart_top #(
  parameter int DATA_BITS = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 tx_start,
  input  logic [DATA_BITS-1:0] tx_data,
  output logic                 tx_busy,
  output logic                 txd,
  input  logic                 rxd,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_ready,
  output logic                 rx_busy,
`ifdef UART_FRAME_ERR_EN
  output logic                 rx_frame_err,
`endif
  input  logic [15:0]          prescale
);

  localparam int          BIT_W    = $clog2(DATA_BITS);
  localparam logic [15:0] MIN_PER  = 16'd4;
  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_BITS - 1);

  typedef enum logic [1:0] {ST_IDLE, ST_START, ST_DATA, ST_STOP} state_t;

  logic [15:0] period_w;
  assign period_w = (prescale < MIN_PER) ? MIN_PER : prescale;

  // ---------------- transmitter ----------------
  state_t                 tx_state_q, tx_state_d;
  logic [15:0]            tx_cnt_q, tx_cnt_d, tx_per_q, tx_per_d;
  logic [BIT_W-1:0]       tx_bit_q, tx_bit_d;
  logic [DATA_BITS-1:0]   tx_shift_q, tx_shift_d;
  logic                   txd_q, txd_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_state_q <= ST_IDLE;
      tx_cnt_q   <= '0;
      tx_per_q   <= MIN_PER;
      tx_bit_q   <= '0;
      tx_shift_q <= '0;
      txd_q      <= 1'b1;
    end else begin
      tx_state_q <= tx_state_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_per_q   <= tx_per_d;
      tx_bit_q   <= tx_bit_d;
      tx_shift_q <= tx_shift_d;
      txd_q      <= txd_d;
    end
  end

  always_comb begin
    tx_state_d = tx_state_q;
    tx_cnt_d   = tx_cnt_q;
    tx_per_d   = tx_per_q;
    tx_bit_d   = tx_bit_q;
    tx_shift_d = tx_shift_q;
    txd_d      = txd_q;
    case (tx_state_q)
      ST_IDLE: begin
        txd_d = 1'b1;
        if (tx_start) begin
          tx_state_d = ST_START;
          tx_per_d   = period_w;
          tx_cnt_d   = period_w - 16'd1;
          tx_shift_d = tx_data;
          txd_d      = 1'b0;
        end
      end
      ST_START: begin
        if (tx_cnt_q == '0) begin
          tx_state_d = ST_DATA;
          tx_cnt_d   = tx_per_q - 16'd1;
          tx_bit_d   = '0;
          txd_d      = tx_shift_q[0];
        end else begin
          tx_cnt_d = tx_cnt_q - 16'd1;
        end
      end
      ST_DATA: begin
        if (tx_cnt_q == '0) begin
          tx_cnt_d   = tx_per_q - 16'd1;
          tx_shift_d = tx_shift_q >> 1;
          if (tx_bit_q == LAST_BIT) begin
            tx_state_d = ST_STOP;
            txd_d      = 1'b1;
          end else begin
            tx_bit_d = tx_bit_q + 1'b1;
            txd_d    = tx_shift_q[1];
          end
        end else begin
          tx_cnt_d = tx_cnt_q - 16'd1;
        end
      end
      default: begin
        if (tx_cnt_q == '0) tx_state_d = ST_IDLE;
        else                tx_cnt_d   = tx_cnt_q - 16'd1;
      end
    endcase
  end

  assign tx_busy = (tx_state_q != ST_IDLE);
  assign txd     = txd_q;

  // ---------------- receiver ----------------
  logic [1:0]             sync_q;
  logic                   rx_prev_q;
  logic                   rxs_w;
  state_t                 rx_state_q, rx_state_d;
  logic [15:0]            rx_cnt_q, rx_cnt_d, rx_per_q, rx_per_d;
  logic [BIT_W-1:0]       rx_bit_q, rx_bit_d;
  logic [DATA_BITS-1:0]   rx_shift_q, rx_shift_d, rx_data_q, rx_data_d;
  logic                   rx_ready_q, rx_ready_d;
`ifdef UART_FRAME_ERR_EN
  logic                   ferr_q, ferr_d;
`endif

  assign rxs_w = sync_q[1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q     <= 2'b11;
      rx_prev_q  <= 1'b1;
      rx_state_q <= ST_IDLE;
      rx_cnt_q   <= '0;
      rx_per_q   <= MIN_PER;
      rx_bit_q   <= '0;
      rx_shift_q <= '0;
      rx_data_q  <= '0;
      rx_ready_q <= 1'b0;
`ifdef UART_FRAME_ERR_EN
      ferr_q     <= 1'b0;
`endif
    end else begin
      sync_q     <= {sync_q[0], rxd};
      rx_prev_q  <= rxs_w;
      rx_state_q <= rx_state_d;
      rx_cnt_q   <= rx_cnt_d;
      rx_per_q   <= rx_per_d;
      rx_bit_q   <= rx_bit_d;
      rx_shift_q <= rx_shift_d;
      rx_data_q  <= rx_data_d;
      rx_ready_q <= rx_ready_d;
`ifdef UART_FRAME_ERR_EN
      ferr_q     <= ferr_d;
`endif
    end
  end

  always_comb begin
    rx_state_d = rx_state_q;
    rx_cnt_d   = rx_cnt_q;
    rx_per_d   = rx_per_q;
    rx_bit_d   = rx_bit_q;
    rx_shift_d = rx_shift_q;
    rx_data_d  = rx_data_q;
    rx_ready_d = 1'b0;
`ifdef UART_FRAME_ERR_EN
    ferr_d     = 1'b0;
`endif
    case (rx_state_q)
      ST_IDLE: begin
        // Falling edge only; a held-low line (break) never re-triggers.
        if (rx_prev_q && !rxs_w) begin
          rx_state_d = ST_START;
          rx_per_d   = period_w;
          rx_cnt_d   = (period_w >> 1) - 16'd1;
        end
      end
      ST_START: begin
        if (rx_cnt_q == '0) begin
          if (rxs_w) begin
            rx_state_d = ST_IDLE;
          end else begin
            rx_state_d = ST_DATA;
            rx_cnt_d   = rx_per_q - 16'd1;
            rx_bit_d   = '0;
          end
        end else begin
          rx_cnt_d = rx_cnt_q - 16'd1;
        end
      end
      ST_DATA: begin
        if (rx_cnt_q == '0) begin
          rx_shift_d = {rxs_w, rx_shift_q[DATA_BITS-1:1]};
          rx_cnt_d   = rx_per_q - 16'd1;
          if (rx_bit_q == LAST_BIT) rx_state_d = ST_STOP;
          else                      rx_bit_d   = rx_bit_q + 1'b1;
        end else begin
          rx_cnt_d = rx_cnt_q - 16'd1;
        end
      end
      default: begin
        if (rx_cnt_q == '0) begin
          rx_state_d = ST_IDLE;
          if (rxs_w) begin
            rx_data_d  = rx_shift_q;
            rx_ready_d = 1'b1;
          end
`ifdef UART_FRAME_ERR_EN
          else begin
            ferr_d = 1'b1;
          end
`endif
        end else begin
          rx_cnt_d = rx_cnt_q - 16'd1;
        end
      end
    endcase
  end

  assign rx_busy  = (rx_state_q != ST_IDLE);
  assign rx_data  = rx_data_q;
  assign rx_ready = rx_ready_q;
`ifdef UART_FRAME_ERR_EN
  assign rx_frame_err = ferr_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_uart_top.sv
`default_nettype none
// tb_uart_top : randomized loopback and directly driven RX frames, checked
// against a frame-level model (bit index = cycle / period, byte scoreboard).
module tb_uart_top;

  logic        clk = 1'b0;
  logic        rst;
  logic        tx_start;
  logic [7:0]  tx_data;
  logic        tx_busy;
  logic        txd;
  logic        rxd;
  logic [7:0]  rx_data;
  logic        rx_ready;
  logic        rx_busy;
  logic [15:0] prescale;
`ifdef UART_FRAME_ERR_EN
  logic        rx_frame_err;
  int          ferr_cnt = 0;
`endif

  logic        loop_en;
  logic        rxd_drv;
  int          checks = 0;
  int          errors = 0;
  logic [7:0]  rq[$];
  logic [7:0]  exp_rx;

  always #5 clk = ~clk;
  assign rxd = loop_en ? txd : rxd_drv;

  uart_top dut (
    .clk(clk), .rst(rst), .tx_start(tx_start), .tx_data(tx_data),
    .tx_busy(tx_busy), .txd(txd), .rxd(rxd), .rx_data(rx_data),
    .rx_ready(rx_ready), .rx_busy(rx_busy),
`ifdef UART_FRAME_ERR_EN
    .rx_frame_err(rx_frame_err),
`endif
    .prescale(prescale)
  );

  always @(negedge clk) begin
    if (rx_ready === 1'b1) rq.push_back(rx_data);
`ifdef UART_FRAME_ERR_EN
    if (rx_frame_err === 1'b1) ferr_cnt++;
`endif
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic int eff_p(input int raw);
    return (raw < 4) ? 4 : raw;
  endfunction

  // Serial line level for bit slot idx of an 8N1 frame (0 = start, 9 = stop).
  function automatic logic frame_bit(input logic [7:0] d, input int idx);
    if (idx == 0) return 1'b0;
    if (idx >= 9) return 1'b1;
    return d[idx-1];
  endfunction

  task automatic send_frame(input logic [7:0] d, input int raw_p, input bit disturb);
    int p;
    int k;
    p = eff_p(raw_p);
    prescale = 16'(raw_p);
    tx_data  = d;
    tx_start = 1'b1;
    @(posedge clk); #1;
    tx_start = 1'b0;
    tx_data  = 8'($urandom);
    k = 0;
    while (tx_busy === 1'b1 && k < 10*p + 5) begin
      if (k % p == p/2 && k/p < 10)
        check($sformatf("txd bit%0d p=%0d", k/p, p), txd, frame_bit(d, k/p));
      if (k == p) prescale = 16'($urandom_range(0, 200));
      tx_start = (disturb && k == 3*p);
      @(posedge clk); #1;
      k++;
    end
    tx_start = 1'b0;
    check($sformatf("tx_busy cycles p=%0d", p), k, 10*p);
  endtask

  task automatic expect_rx(input logic [7:0] d, input int p);
    int n;
    logic [7:0] b;
    n = 0;
    while (rq.size() == 0 && n < 2*p + 20) begin
      tick(1);
      n++;
    end
    tick(2);
    check("rx_ready pulses", rq.size(), 1);
    b = 8'hxx;
    if (rq.size() > 0) b = rq[0];
    check("rx byte", b, d);
    check("rx_data", rx_data, d);
    rq.delete();
    exp_rx = d;
  endtask

  task automatic drive_rx(input logic [7:0] d, input logic stop, input int bitlen);
    rxd_drv = 1'b0;
    tick(bitlen);
    for (int i = 0; i < 8; i++) begin
      rxd_drv = d[i];
      tick(bitlen);
    end
    rxd_drv = stop;
    tick(bitlen);
  endtask

  initial begin
    logic [7:0] d;
    int         rp;
    rst = 1'b1; tx_start = 1'b0; tx_data = 8'h00; prescale = 16'd16;
    loop_en = 1'b1; rxd_drv = 1'b1; exp_rx = 8'h00;
    tick(3);
    check("reset txd", txd, 1);
    check("reset tx_busy", tx_busy, 0);
    check("reset rx_data", rx_data, 8'h00);
    check("reset rx_ready", rx_ready, 0);
    check("reset rx_busy", rx_busy, 0);
    rst = 1'b0;
    tick(2);

    send_frame(8'hA5, 868, 1'b0);
    expect_rx(8'hA5, 868);
    send_frame(8'h55, 40, 1'b1);
    expect_rx(8'h55, 40);
    send_frame(8'hFF, 100, 1'b0);
    expect_rx(8'hFF, 100);
    send_frame(8'h00, 2, 1'b0);
    expect_rx(8'h00, 4);

    for (int i = 0; i < 16; i++) begin
      d  = 8'($urandom);
      rp = $urandom_range(0, 48);
      send_frame(d, rp, (i % 2) == 1);
      expect_rx(d, eff_p(rp));
    end

    // Short low glitch on the line: start bit rejected at mid-bit.
    loop_en = 1'b0; rxd_drv = 1'b1; prescale = 16'd100;
    tick(5);
    rxd_drv = 1'b0;
    tick(25);
    rxd_drv = 1'b1;
    check("glitch rx_busy high", rx_busy, 1);
    tick(60);
    check("glitch rx_busy low", rx_busy, 0);
    check("glitch no ready", rq.size(), 0);
    check("glitch rx_data", rx_data, exp_rx);

    // Framing error followed by a break held low.
    drive_rx(8'h5A, 1'b0, 100);
    tick(400);
    check("ferr rx_busy", rx_busy, 0);
    check("ferr no ready", rq.size(), 0);
    check("ferr rx_data", rx_data, exp_rx);
`ifdef UART_FRAME_ERR_EN
    check("ferr pulses", ferr_cnt, 1);
`endif
    rxd_drv = 1'b1;
    tick(10);

    // Sender 3% slow and 3% fast relative to P = 100.
    d = 8'($urandom);
    drive_rx(d, 1'b1, 103);
    expect_rx(d, 100);
    d = 8'($urandom);
    drive_rx(d, 1'b1, 97);
    expect_rx(d, 100);

    // Reset in the middle of a loopback frame.
    loop_en = 1'b1; prescale = 16'd50; tx_data = 8'($urandom); tx_start = 1'b1;
    tick(1);
    tx_start = 1'b0;
    tick(150);
    check("pre-reset tx_busy", tx_busy, 1);
    check("pre-reset rx_busy", rx_busy, 1);
    #2 rst = 1'b1;
    #1;
    check("mid reset txd", txd, 1);
    check("mid reset tx_busy", tx_busy, 0);
    check("mid reset rx_busy", rx_busy, 0);
    check("mid reset rx_data", rx_data, 8'h00);
    exp_rx = 8'h00;
    tick(3);
    rst = 1'b0;
    tick(5);
    check("no partial byte", rq.size(), 0);
    d = 8'($urandom);
    send_frame(d, 20, 1'b0);
    expect_rx(d, 20);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
